// File: rtl/patch_request_sequencer_if.sv
// patch_request_sequencer_if: upstream valid/ready request port and downstream valid/ready result port.
// The master modport is the side that issues transactions and consumes results.
interface patch_request_sequencer_if #(
    parameter int N          = 16,
    parameter int ADDR_WIDTH = 21
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_rw;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [N-1:0]          in_wdata;
    logic [N-1:0]          in_org;
    logic                  in_p;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_data;
    logic                  out_error;
    logic                  out_timeout;

    modport master (
        output in_valid, in_rw, in_addr, in_wdata, in_org, in_p, out_ready,
        input  in_ready, out_valid, out_data, out_error, out_timeout
    );

    modport slave (
        input  in_valid, in_rw, in_addr, in_wdata, in_org, in_p, out_ready,
        output in_ready, out_valid, out_data, out_error, out_timeout
    );
endinterface

// File: rtl/patch_request_sequencer.sv
// patch_request_sequencer: one-at-a-time cache transaction sequencer with bounded response wait.
// Define PATCH_SEQ_STATS_EN to build the saturating req_count/fail_count statistics registers.
module patch_request_sequencer #(
    parameter int N          = 16,
    parameter int ADDR_WIDTH = 21,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    patch_request_sequencer_if.slave bus,
    output logic                  request,
    output logic                  read_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [N-1:0]          activation_in,
    output logic [N-1:0]          activation_org,
    output logic                  p,
    input  logic [N-1:0]          chosen_activation,
    input  logic                  valid,
    input  logic                  error,
    output logic [15:0]           req_count,
    output logic [15:0]           fail_count
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  request_q, request_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [N-1:0]          wdata_q, wdata_d;
    logic [N-1:0]          org_q, org_d;
    logic                  p_q, p_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [N-1:0]          out_data_q, out_data_d;
    logic                  out_error_q, out_error_d;
    logic                  out_timeout_q, out_timeout_d;

    always_comb begin
        state_d       = state_q;
        request_d     = 1'b0;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        org_d         = org_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_error_d   = out_error_q;
        out_timeout_d = out_timeout_q;
        case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                rw_d      = bus.in_rw;
                addr_d    = bus.in_addr;
                wdata_d   = bus.in_wdata;
                org_d     = bus.in_org;
                p_d       = bus.in_p;
                request_d = 1'b1;
                state_d   = REQ;
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (error) begin
                out_error_d = 1'b1;
                out_data_d  = '0;
                state_d     = RESP;
            end else if (valid) begin
                out_data_d = rw_q ? chosen_activation : '0;
                state_d    = RESP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                out_timeout_d = 1'b1;
                out_data_d    = '0;
                state_d       = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: if (bus.out_ready) begin
                out_error_d   = 1'b0;
                out_timeout_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == RESP;
    end

    // in_ready is a flop that resets low so nothing is accepted while reset is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            request_q     <= 1'b0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            org_q         <= '0;
            p_q           <= 1'b0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_error_q   <= 1'b0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            request_q     <= request_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            org_q         <= org_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_error_q   <= out_error_d;
            out_timeout_q <= out_timeout_d;
        end
    end

`ifdef PATCH_SEQ_STATS_EN
    logic [15:0] req_count_q, req_count_d;
    logic [15:0] fail_count_q, fail_count_d;
    logic        hs;

    always_comb begin
        hs           = state_q == RESP && bus.out_ready;
        req_count_d  = (hs && req_count_q != 16'hFFFF) ? req_count_q + 16'd1 : req_count_q;
        fail_count_d = (hs && (out_error_q || out_timeout_q) && fail_count_q != 16'hFFFF)
                       ? fail_count_q + 16'd1 : fail_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_count_q  <= '0;
            fail_count_q <= '0;
        end else begin
            req_count_q  <= req_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign req_count  = req_count_q;
    assign fail_count = fail_count_q;
`else
    assign req_count  = '0;
    assign fail_count = '0;
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_error   = out_error_q;
    assign bus.out_timeout = out_timeout_q;
    assign request         = request_q;
    assign read_write      = rw_q;
    assign address         = addr_q;
    assign activation_in   = wdata_q;
    assign activation_org  = org_q;
    assign p               = p_q;
endmodule

// File: tb/tb_patch_request_sequencer.sv
// tb_patch_request_sequencer: directed scenarios for the sequencer built with TIMEOUT=4.
// Statistics expectations follow whether PATCH_SEQ_STATS_EN is defined for the build.
module tb_patch_request_sequencer;
`ifdef PATCH_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        request, read_write, p, valid, error;
    logic [20:0] address;
    logic [15:0] activation_in, activation_org, chosen_activation, req_count, fail_count;
    int          errors = 0;
    int          checks = 0;
    int          exp_req = 0;
    int          exp_fail = 0;
    int          lat;

    patch_request_sequencer_if #(.N(16), .ADDR_WIDTH(21)) bus ();

    patch_request_sequencer #(.N(16), .ADDR_WIDTH(21), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .request(request), .read_write(read_write),
        .address(address), .activation_in(activation_in), .activation_org(activation_org), .p(p),
        .chosen_activation(chosen_activation), .valid(valid), .error(error),
        .req_count(req_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Drive one acceptance; returns at the negedge of the REQ cycle (cycle k+1)
    task automatic accept(input logic rw, input logic [20:0] a, input logic [15:0] wd, input logic [15:0] org, input logic pb);
        bus.in_valid = 1'b1; bus.in_rw = rw; bus.in_addr = a; bus.in_wdata = wd; bus.in_org = org; bus.in_p = pb;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Present a response in cycle k+resp_cyc; lat is the cycle out_valid is first seen, -1 if never
    task automatic wait_resp(input int resp_cyc, input logic v, input logic e, output int l);
        l = -1;
        for (int c = 1; c < 40; c++) begin
            if (bus.out_valid) begin
                l = c;
                break;
            end
            valid = (c == resp_cyc) && v;
            error = (c == resp_cyc) && e;
            @(negedge clk);
        end
        valid = 1'b0; error = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_stats(input string name);
        checks++; if (req_count !== 16'(STATS ? exp_req : 0)) begin errors++; $display("FAIL %s req_count: got %0d want %0d", name, req_count, STATS ? exp_req : 0); end
        checks++; if (fail_count !== 16'(STATS ? exp_fail : 0)) begin errors++; $display("FAIL %s fail_count: got %0d want %0d", name, fail_count, STATS ? exp_fail : 0); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        checks++; if (request !== 1'b0 || address !== 21'd0 || activation_in !== 16'd0) begin errors++; $display("FAIL reset cache side: got req=%b addr=%h act=%h want 0", request, address, activation_in); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0) begin errors++; $display("FAIL reset out: got v=%b d=%h want 0", bus.out_valid, bus.out_data); end
        check_stats("reset");
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_read_hit();
        chosen_activation = 16'hBEEF;
        accept(1'b1, 21'h00010, 16'h0000, 16'h1234, 1'b1);
        checks++; if (request !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL hit req cycle: got req=%b rdy=%b want 1/0", request, bus.in_ready); end
        checks++; if (address !== 21'h00010 || read_write !== 1'b1 || activation_org !== 16'h1234 || p !== 1'b1) begin errors++; $display("FAIL hit cache side: got a=%h rw=%b org=%h p=%b", address, read_write, activation_org, p); end
        @(negedge clk);
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL hit request width: got %b want 0", request); end
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF) begin errors++; $display("FAIL hit result: got v=%b d=%h want 1/beef", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_error !== 1'b0 || bus.out_timeout !== 1'b0) begin errors++; $display("FAIL hit status: got e=%b t=%b want 0/0", bus.out_error, bus.out_timeout); end
        handshake();
        exp_req++;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL hit after hs: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        check_stats("hit");
    endtask

    task automatic test_write();
        chosen_activation = 16'h5555;
        accept(1'b0, 21'h00155, 16'h00FF, 16'hAAAA, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (activation_in !== 16'h00FF || read_write !== 1'b0) begin errors++; $display("FAIL write hold c%0d: got act=%h rw=%b want 00ff/0", c, activation_in, read_write); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL write early c%0d: got out_valid=%b want 0", c, bus.out_valid); end
            valid = (c == 4);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000) begin errors++; $display("FAIL write result: got v=%b d=%h want 1/0000", bus.out_valid, bus.out_data); end
        handshake();
        exp_req++;
        check_stats("write");
    endtask

    task automatic test_error_priority();
        chosen_activation = 16'h7777;
        accept(1'b1, 21'h00020, 16'h0000, 16'h0001, 1'b0);
        wait_resp(2, 1'b1, 1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL err latency: got %0d want 3", lat); end
        checks++; if (bus.out_error !== 1'b1 || bus.out_data !== 16'h0000 || bus.out_timeout !== 1'b0) begin errors++; $display("FAIL err result: got e=%b d=%h t=%b want 1/0000/0", bus.out_error, bus.out_data, bus.out_timeout); end
        handshake();
        exp_req++; exp_fail++;
        checks++; if (bus.out_error !== 1'b0) begin errors++; $display("FAIL err clear: got %b want 0", bus.out_error); end
        check_stats("error");
    endtask

    task automatic test_timeout();
        chosen_activation = 16'h1111;
        accept(1'b1, 21'h00030, 16'h0000, 16'h0002, 1'b1);
        wait_resp(0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL timeout latency: got %0d want 6", lat); end
        checks++; if (bus.out_timeout !== 1'b1 || bus.out_error !== 1'b0 || bus.out_data !== 16'h0000) begin errors++; $display("FAIL timeout result: got t=%b e=%b d=%h want 1/0/0000", bus.out_timeout, bus.out_error, bus.out_data); end
        valid = 1'b1; error = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b0; error = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_timeout !== 1'b1 || bus.out_error !== 1'b0 || bus.out_data !== 16'h0000) begin errors++; $display("FAIL late resp ignored: got v=%b t=%b e=%b d=%h", bus.out_valid, bus.out_timeout, bus.out_error, bus.out_data); end
        handshake();
        exp_req++; exp_fail++;
        checks++; if (bus.out_timeout !== 1'b0) begin errors++; $display("FAIL timeout clear: got %b want 0", bus.out_timeout); end
        check_stats("timeout");
    endtask

    task automatic test_timeout_race();
        chosen_activation = 16'h2468;
        accept(1'b1, 21'h00040, 16'h0000, 16'h0003, 1'b0);
        wait_resp(5, 1'b1, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL race latency: got %0d want 6", lat); end
        checks++; if (bus.out_timeout !== 1'b0 || bus.out_data !== 16'h2468) begin errors++; $display("FAIL race result: got t=%b d=%h want 0/2468", bus.out_timeout, bus.out_data); end
        handshake();
        exp_req++;
        check_stats("race");
    endtask

    task automatic test_back_to_back();
        chosen_activation = 16'hCAFE;
        accept(1'b1, 21'h00050, 16'h0000, 16'h0004, 1'b1);
        wait_resp(2, 1'b1, 1'b0, lat);
        chosen_activation = 16'h0BAD;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hCAFE || bus.in_ready !== 1'b0) begin errors++; $display("FAIL backpressure %0d: got v=%b d=%h rdy=%b", i, bus.out_valid, bus.out_data, bus.in_ready); end
            bus.in_valid = ~bus.in_valid;
            bus.in_addr = 21'h00099;
            @(negedge clk);
        end
        bus.in_valid = 1'b1; bus.in_addr = 21'h00022; bus.in_rw = 1'b1;
        handshake();
        exp_req++;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || request !== 1'b0) begin errors++; $display("FAIL b2b after hs: got v=%b rdy=%b req=%b want 0/1/0", bus.out_valid, bus.in_ready, request); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (request !== 1'b1 || address !== 21'h00022 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b accept: got req=%b a=%h rdy=%b want 1/00022/0", request, address, bus.in_ready); end
        chosen_activation = 16'h3C3C;
        wait_resp(2, 1'b1, 1'b0, lat);
        checks++; if (lat !== 3 || bus.out_data !== 16'h3C3C) begin errors++; $display("FAIL b2b second: got lat=%0d d=%h want 3/3c3c", lat, bus.out_data); end
        handshake();
        exp_req++;
        check_stats("b2b");
    endtask

    task automatic test_reset_mid_wait();
        accept(1'b0, 21'h1ABCD, 16'h0F0F, 16'hF0F0, 1'b1);
        @(negedge clk);
        valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        exp_req = 0; exp_fail = 0;
        checks++; if (address !== 21'd0 || activation_in !== 16'd0 || activation_org !== 16'd0 || p !== 1'b0 || request !== 1'b0) begin errors++; $display("FAIL async reset cache side: got a=%h act=%h org=%h p=%b req=%b", address, activation_in, activation_org, p, request); end
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL async reset handshake: got rdy=%b v=%b want 0/0", bus.in_ready, bus.out_valid); end
        check_stats("async reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL post reset: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_rw = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_org = '0; bus.in_p = 1'b0;
        bus.out_ready = 1'b0; valid = 1'b0; error = 1'b0; chosen_activation = '0;
        test_reset();
        test_read_hit();
        test_write();
        test_error_priority();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/patch_request_sequencer.md
# patch_request_sequencer

Transaction sequencer directly upstream of the patching top level (patch cache plus patching mux). Accepts one activation transaction at a time over a valid/ready input port. Drives the cache request, address, write data, original activation and patch bit, and waits for the cache's `valid`/`error` with a bounded timeout. Returns the patched activation, or an error/timeout status, over a valid/ready output port.

## Interface
Parameters:
- `N`, 16, activation width
- `ADDR_WIDTH`, 21, cache address width
- `TIMEOUT`, 15, max WAIT cycles before abort; legal range 1..255

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream transaction valid
- `in_ready`  out  1  sequencer can accept
- `in_rw`  in  1  1 = read, 0 = write
- `in_addr`  in  ADDR_WIDTH  cache address
- `in_wdata`  in  N  write activation
- `in_org`  in  N  original activation
- `in_p`  in  1  patch bit
- `request`  out  1  cache request pulse
- `read_write`  out  1  to cache
- `address`  out  ADDR_WIDTH  to cache
- `activation_in`  out  N  to cache
- `activation_org`  out  N  to patching unit
- `p`  out  1  to patching unit
- `chosen_activation`  in  N  from patching unit
- `valid`  in  1  cache response valid
- `error`  in  1  cache response error
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  N  patched activation (reads), 0 (writes or failures)
- `out_error`  out  1  cache reported error
- `out_timeout`  out  1  no response within TIMEOUT
- `req_count`  out  16  completed transactions (stats)
- `fail_count`  out  16  errors plus timeouts (stats)

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. The reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch `in_*` into the cache-side outputs and go to REQ.
- REQ:
  - `request` = 1 for exactly one cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - `request` = 0. Cache-side outputs are held stable.
  - `valid`/`error` are sampled only in WAIT and ignored in every other state.
  - If `error` = 1: `out_error` = 1, `out_data` = 0, go to RESP. `error` takes priority over a simultaneous `valid`.
  - Else if `valid` = 1: `out_data` = `chosen_activation` when `read_write` = 1, otherwise 0. Go to RESP.
  - Else if the counter equals TIMEOUT-1: `out_timeout` = 1, `out_data` = 0, go to RESP.
  - Otherwise increment the counter. The counter is 8 bits wide.
  - A `valid` arriving in the same cycle the timeout would fire counts as success.
- RESP:
  - `out_valid` = 1. `out_data`, `out_error` and `out_timeout` are held stable until `out_ready` = 1.
  - On `out_ready`, go to IDLE and clear `out_error`/`out_timeout`.
- Cache-side outputs retain their last value in IDLE until the next acceptance.
- Stats counters:
  - `req_count` increments on every RESP handshake.
  - `fail_count` increments on every RESP handshake that carries an error or timeout.
  - Both counters saturate at 0xFFFF.
- Reset mid-transaction: an asserted `reset` returns the FSM to IDLE immediately. Any in-flight cache response is dropped.

## Timing
- Reset values:
  - `in_ready` = 0 while `reset` is low, 1 after release (IDLE).
  - `request`, `read_write`, `address`, `activation_in`, `activation_org`, `p` = 0.
  - `out_valid`, `out_data`, `out_error`, `out_timeout` = 0.
  - `req_count`, `fail_count` = 0.
- Acceptance at edge k → `request` high in cycle k+1 → WAIT from cycle k+2.
- A response in WAIT cycle k+2+j gives `out_valid` from cycle k+3+j.
- Minimum latency from acceptance to `out_valid` is 3 cycles.
- Timeout: with no response, WAIT lasts exactly TIMEOUT cycles, and `out_valid` rises in cycle k+2+TIMEOUT.
- One transaction is in flight at a time. `in_ready` = 0 in REQ, WAIT and RESP. The earliest next acceptance is the cycle after the RESP handshake.
- All outputs are registered. There is no combinational path from `in_*`, `valid`, `error` or `out_ready` to any output.

## Configuration
- `PATCH_SEQ_STATS_EN` defined: `req_count` and `fail_count` are implemented as described.
- `PATCH_SEQ_STATS_EN` undefined: no counter registers are built. `req_count` and `fail_count` are tied to 0. All other behaviour is identical.

## Test plan
- Read hit:
  - Stimulus: accept `in_rw`=1, `in_addr`=0x00010, `in_org`=0x1234, `in_p`=1; cache returns `valid` in the first WAIT cycle with `chosen_activation`=0xBEEF.
  - Required: `request` high for exactly one cycle; `out_valid` 3 cycles after acceptance with `out_data`=0xBEEF and `out_error`=`out_timeout`=0.
- Write:
  - Stimulus: `in_rw`=0, `in_wdata`=0x00FF; `valid` after 2 WAIT cycles.
  - Required: `activation_in`=0x00FF held through WAIT; `out_data`=0; `out_valid` 5 cycles after acceptance.
- Error priority:
  - Stimulus: `valid`=1 and `error`=1 in the same WAIT cycle.
  - Required: `out_error`=1, `out_data`=0, `fail_count` +1 after the handshake (with macro).
- Timeout:
  - Stimulus: TIMEOUT=4, no response.
  - Required: `out_timeout`=1 in cycle k+6; a late `valid` in RESP is ignored.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles in RESP; toggle `in_valid`.
  - Required: `out_data` stable, `in_ready`=0 throughout; next acceptance one cycle after the handshake.
- Reset mid-WAIT:
  - Stimulus: assert `reset` low asynchronously during WAIT.
  - Required: all outputs at reset values immediately; `in_ready`=1 after release.
